// File: rtl/instr_enc.sv
// ============================================================================
// Module   : instr_enc
// Brief    : Register-access encoder: serialises one read/write request as a
//            command byte then a data byte, returns read data on completion.
//            Optional wait timeout enabled by defining INSTR_ENC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_enc #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       rx_sync,
  input  logic [7:0] rx_byte,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    CMD_WAIT  = 3'd2,
    DATA      = 3'd3,
    DATA_WAIT = 3'd4,
    RESP      = 3'd5
  } state_t;

  localparam logic [7:0] c_RD_FILL = 8'h00;
  localparam logic [7:0] c_TO_DATA = 8'hFF;

  state_t     r_state;
  state_t     w_next;
  logic       r_rw;
  logic [5:0] r_addr;
  logic [7:0] r_wdata;
  logic       w_in_wait;
  logic       w_timeout;

  // A zero limit has no sensible meaning; such a build keeps the limit unused.
  if (TIMEOUT_CYCLES == 0) begin : g_zero_limit
  end

  assign w_in_wait = (r_state == CMD_WAIT) || (r_state == DATA_WAIT);

`ifdef INSTR_ENC_TIMEOUT_EN
  localparam int                  c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LIMIT  = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_rsp_err;

  // Counter restarts on every state change, so each wait state starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (!w_in_wait || (w_next != r_state)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + c_ONE;
    end
  end

  // rx_sync is tested first in the FSM, so it wins over a simultaneous timeout.
  assign w_timeout = w_in_wait && (r_wait_cnt == c_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if (w_in_wait && !rx_sync && w_timeout) begin
      r_rsp_err <= 1'b1;
    end else if (r_state == DATA_WAIT && rx_sync) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    tx_valid  = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) w_next = CMD;
      end
      CMD: begin
        tx_valid = 1'b1;
        if (tx_ready) w_next = CMD_WAIT;
      end
      CMD_WAIT: begin
        if (rx_sync)        w_next = DATA;
        else if (w_timeout) w_next = RESP;
      end
      DATA: begin
        tx_valid = 1'b1;
        if (tx_ready) w_next = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (rx_sync || w_timeout) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // tx_byte is loaded on entry to CMD/DATA and otherwise holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw      <= 1'b0;
      r_addr    <= 6'd0;
      r_wdata   <= 8'h00;
      tx_byte   <= 8'h00;
      rsp_rdata <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_rw    <= req_rw;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            tx_byte <= {req_rw, 1'b0, req_addr};
          end
        end
        CMD_WAIT: begin
          if (rx_sync) begin
            tx_byte <= r_rw ? r_wdata : c_RD_FILL;
          end else if (w_timeout) begin
            rsp_rdata <= c_TO_DATA;
          end
        end
        DATA_WAIT: begin
          if (rx_sync) begin
            rsp_rdata <= r_rw ? 8'h00 : rx_byte;
          end else if (w_timeout) begin
            rsp_rdata <= c_TO_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // The latched address only feeds tx_byte at accept time; kept for visibility.
  logic w_addr_unused;
  assign w_addr_unused = ^r_addr;

endmodule

`default_nettype wire

// File: tb/tb_instr_enc.sv
// ============================================================================
// Module   : tb_instr_enc
// Brief    : Directed self-checking bench for instr_enc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       rx_sync;
  logic [7:0] rx_byte;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  int total = 0;
  int bad   = 0;
  int rsp_cnt = 0;

  instr_enc #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_sync   (rx_sync),
    .rx_byte   (rx_byte),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Full transaction with tx_ready/rx_sync answered in the first awaited cycle.
  task automatic do_txn(input string tag, input logic rw, input logic [5:0] addr,
                        input logic [7:0] wd, input logic [7:0] rx1, input logic [7:0] rx2,
                        input logic [7:0] exp_cmd, input logic [7:0] exp_data,
                        input logic [7:0] exp_rdata);
    int n0;
    n0 = rsp_cnt;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    chk({tag, "/ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0; req_rw = ~rw; req_addr = 6'h00; req_wdata = 8'h00;
    chk({tag, "/cmd_valid"}, tx_valid, 1);
    chk({tag, "/cmd_byte"}, tx_byte, exp_cmd);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({tag, "/cwait_valid"}, tx_valid, 0);
    rx_sync = 1'b1; rx_byte = rx1;
    tick();
    rx_sync = 1'b0;
    chk({tag, "/data_valid"}, tx_valid, 1);
    chk({tag, "/data_byte"}, tx_byte, exp_data);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    rx_sync = 1'b1; rx_byte = rx2;
    tick();
    rx_sync = 1'b0;
    chk({tag, "/rsp_valid"}, rsp_valid, 1);
    chk({tag, "/rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "/rsp_err"}, rsp_err, 0);
    tick();
    chk({tag, "/rsp_drop"}, rsp_valid, 0);
    chk({tag, "/idle_ready"}, req_ready, 1);
    chk({tag, "/rsp_count"}, rsp_cnt, n0 + 1);
  endtask

  initial begin
    int n0;
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 6'h00; req_wdata = 8'h00;
    tx_ready = 1'b0; rx_sync = 1'b0; rx_byte = 8'h00;

    // Reset values
    tick();
    chk("rst/req_ready", req_ready, 0);
    chk("rst/tx_valid", tx_valid, 0);
    chk("rst/tx_byte", tx_byte, 8'h00);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/rsp_rdata", rsp_rdata, 8'h00);
    chk("rst/rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();
    chk("rst/ready_after", req_ready, 1);

    // Read addr 0x2A, second rx_sync carries 0x3C
    do_txn("read2a", 1'b0, 6'h2A, 8'h55, 8'hE1, 8'h3C, 8'h2A, 8'h00, 8'h3C);
    tick();
    chk("read2a/rdata_hold", rsp_rdata, 8'h3C);

    // Write addr 0x05 data 0xA5
    do_txn("wr05", 1'b1, 6'h05, 8'hA5, 8'h11, 8'h22, 8'h85, 8'hA5, 8'h00);

    // tx_ready low for 10 cycles in CMD, with rx_sync noise
    n0 = rsp_cnt;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 6'h3F; req_wdata = 8'hC3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall/valid%0d", i), tx_valid, 1);
      chk($sformatf("stall/byte%0d", i), tx_byte, 8'hBF);
      rx_sync = (i % 3 == 1); rx_byte = 8'h99;
      tick();
    end
    rx_sync = 1'b0;
    chk("stall/still_cmd", tx_byte, 8'hBF);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    chk("stall/data_byte", tx_byte, 8'hC3);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    rx_sync = 1'b1; rx_byte = 8'h77; tick(); rx_sync = 1'b0;
    chk("stall/rsp_valid", rsp_valid, 1);
    chk("stall/rsp_rdata", rsp_rdata, 8'h00);
    tick();
    chk("stall/rsp_count", rsp_cnt, n0 + 1);

    // Stray rx_sync in IDLE, then a second req_valid mid-transaction
    n0 = rsp_cnt;
    rx_sync = 1'b1; rx_byte = 8'hEE;
    tick(); tick();
    rx_sync = 1'b0;
    chk("stray/ready", req_ready, 1);
    chk("stray/tx_valid", tx_valid, 0);
    chk("stray/no_rsp", rsp_cnt, n0);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h15; req_wdata = 8'h00;
    tick();
    req_rw = 1'b1; req_addr = 6'h01; req_wdata = 8'h99;
    chk("midreq/cmd_byte", tx_byte, 8'h15);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    chk("midreq/data_byte", tx_byte, 8'h00);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    req_valid = 1'b0;
    rx_sync = 1'b1; rx_byte = 8'hC7; tick(); rx_sync = 1'b0;
    chk("midreq/rsp_rdata", rsp_rdata, 8'hC7);
    tick();
    chk("midreq/idle_tx", tx_valid, 0);
    tick();
    chk("midreq/no_new_txn", tx_valid, 0);
    chk("midreq/rsp_count", rsp_cnt, n0 + 1);

    // Reset pulsed in DATA_WAIT
    n0 = rsp_cnt;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 6'h0A; req_wdata = 8'h5F;
    tick();
    req_valid = 1'b0;
    chk("rstmid/cmd_byte", tx_byte, 8'h8A);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    rst = 1'b1; rx_sync = 1'b1;
    #1;
    chk("rstmid/req_ready", req_ready, 0);
    chk("rstmid/tx_valid", tx_valid, 0);
    chk("rstmid/tx_byte", tx_byte, 8'h00);
    chk("rstmid/rsp_valid", rsp_valid, 0);
    chk("rstmid/rsp_rdata", rsp_rdata, 8'h00);
    chk("rstmid/rsp_err", rsp_err, 0);
    tick();
    rst = 1'b0; rx_sync = 1'b0;
    tick();
    chk("rstmid/ready_after", req_ready, 1);
    chk("rstmid/no_rsp", rsp_cnt, n0);
    do_txn("postrst", 1'b0, 6'h00, 8'h00, 8'h42, 8'h81, 8'h00, 8'h00, 8'h81);

`ifdef INSTR_ENC_TIMEOUT_EN
    // No rx_sync after the command byte: timeout after 8 wait cycles
    n0 = rsp_cnt;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h07;
    tick();
    req_valid = 1'b0;
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tmo/wait%0d", i), rsp_valid, 0);
      tick();
    end
    chk("tmo/rsp_valid", rsp_valid, 1);
    chk("tmo/rsp_err", rsp_err, 1);
    chk("tmo/rsp_rdata", rsp_rdata, 8'hFF);
    tick();
    chk("tmo/idle", req_ready, 1);
    chk("tmo/rsp_count", rsp_cnt, n0 + 1);

    // rx_sync on the limit cycle wins over the timeout
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h07;
    tick();
    req_valid = 1'b0;
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rx_sync = 1'b1; tick(); rx_sync = 1'b0;
    chk("tmoprio/data_valid", tx_valid, 1);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    rx_sync = 1'b1; rx_byte = 8'h6D; tick(); rx_sync = 1'b0;
    chk("tmoprio/rsp_err", rsp_err, 0);
    chk("tmoprio/rsp_rdata", rsp_rdata, 8'h6D);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the number of cycles to wait for rx_sync before aborting; used only with INSTR_ENC_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: a transaction request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the encoder is idle and can accept a request.
REQ-006 SHALL have port req_rw, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, 6 bits: register address.
REQ-008 SHALL have port req_wdata, input, 8 bits: write data.
REQ-009 SHALL have port tx_byte, output, 8 bits: byte offered to the serial link.
REQ-010 SHALL have port tx_valid, output, 1 bit: tx_byte is valid.
REQ-011 SHALL have port tx_ready, input, 1 bit: the link accepts tx_byte this cycle.
REQ-012 SHALL have port rx_sync, input, 1 bit: one-cycle pulse marking the end of a byte exchange.
REQ-013 SHALL have port rx_byte, input, 8 bits: byte received during that exchange; valid while rx_sync=1.
REQ-014 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse marking transaction completion.
REQ-015 SHALL have port rsp_rdata, output, 8 bits: read data.
REQ-016 SHALL have port rsp_err, output, 1 bit: completion was by timeout; qualified by rsp_valid.

Function
REQ-017 SHALL use FSM states IDLE, CMD, CMD_WAIT, DATA, DATA_WAIT, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; in IDLE with req_valid=1, SHALL latch rw, addr and wdata and go to CMD on the next edge.
REQ-019 SHALL form the command byte as {rw, 1'b0, addr[5:0]}.
REQ-020 In CMD, SHALL drive tx_valid=1 with tx_byte=command byte, held stable until tx_ready=1, then go to CMD_WAIT.
REQ-021 In CMD_WAIT, SHALL go to DATA on rx_sync=1 and discard rx_byte.
REQ-022 In DATA, SHALL drive tx_valid=1 with tx_byte = latched wdata for a write, 8'h00 for a read; on tx_ready=1 SHALL go to DATA_WAIT.
REQ-023 In DATA_WAIT, on rx_sync=1 SHALL capture rx_byte into rsp_rdata for a read, load 8'h00 for a write, and go to RESP.
REQ-024 In RESP, SHALL assert rsp_valid=1 for exactly one cycle with rsp_err=0, then return to IDLE.
REQ-025 Minimum latency, req accept to rsp_valid, with tx_ready and rx_sync each arriving the cycle after they are awaited: 6 cycles.
REQ-026 SHALL ignore rx_sync in IDLE, CMD, DATA and RESP.
REQ-027 SHALL ignore req_valid outside IDLE; the latched request SHALL NOT change mid-transaction.
REQ-028 tx_valid SHALL be 0 in IDLE, CMD_WAIT, DATA_WAIT and RESP, and tx_byte SHALL hold its last value there.
REQ-029 rsp_rdata SHALL hold its value until the next completion.

Reset
REQ-030 While rst=1, SHALL force state=IDLE, req_ready=0, tx_valid=0, tx_byte=8'h00, rsp_valid=0, rsp_rdata=8'h00, rsp_err=0, latched fields=0, timeout counter=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no rsp_valid; req_ready=1 the first cycle after rst deasserts.

Configuration
REQ-032 With INSTR_ENC_TIMEOUT_EN defined, SHALL count cycles in CMD_WAIT and DATA_WAIT, clearing the counter on each state entry.
REQ-033 With INSTR_ENC_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without rx_sync SHALL go to RESP with rsp_err=1 and rsp_rdata=8'hFF.
REQ-034 With INSTR_ENC_TIMEOUT_EN defined, rx_sync in the same cycle the limit is reached SHALL take priority, giving normal completion.
REQ-035 Without INSTR_ENC_TIMEOUT_EN, SHALL have no counter logic, wait indefinitely, and tie rsp_err to 0.

Verification
REQ-036 Bench SHALL cover: write rw=1 addr=0x05 wdata=0xA5 -> tx bytes 0x85 then 0xA5; rsp_valid once; rsp_rdata=0x00.
REQ-037 Bench SHALL cover: read addr=0x2A, rx_byte=0x3C on the second rx_sync -> tx bytes 0x2A then 0x00; rsp_rdata=0x3C; rsp_err=0.
REQ-038 Bench SHALL cover: tx_ready held low 10 cycles in CMD -> tx_valid=1 and tx_byte stable all 10 cycles; no state advance.
REQ-039 Bench SHALL cover: stray rx_sync in IDLE, and a second req_valid mid-transaction -> both ignored; one response only.
REQ-040 Bench SHALL cover: rst pulsed in DATA_WAIT -> no rsp_valid; all outputs at reset values; next request completes normally.
REQ-041 Bench SHALL cover, with INSTR_ENC_TIMEOUT_EN and TIMEOUT_CYCLES=8: no rx_sync after the command byte -> rsp_valid with rsp_err=1 and rsp_rdata=0xFF; then IDLE.
